// File: rtl/temp_led_pkg.sv
// Shared constants for the LED temperature meter: default parameters,
// the threshold table and the level-width helper.
package temp_led_pkg;

    localparam int DEF_ADC_W    = 12;
    localparam int DEF_LED_W    = 8;
    localparam int DEF_NUM_TH   = 6;
    localparam int DEF_AVG_LOG2 = 2;
    localparam int DEF_HYST     = 4;
    localparam int DEF_ALARM_N  = 3;

    // Thresholds in ADC counts, strictly descending (30 C .. 80 C).
    // A lower reading means a hotter sensor.
    localparam int TH_MAX = 6;
    localparam int TEMP_TH [TH_MAX] = '{3666, 3643, 3625, 3595, 3576, 3550};

    // Bits needed to hold a level in 0..num_th
    function automatic int level_width(input int num_th);
        return (num_th < 1) ? 1 : $clog2(num_th + 1);
    endfunction

endpackage

// File: rtl/temp_avg.sv
// Window averager: sums 2^AVG_LOG2 accepted samples and registers their
// truncated mean with a one-cycle mean_vld pulse. Dropping en discards
// any partial window.
module temp_avg import temp_led_pkg::*; #(
    parameter int ADC_W    = DEF_ADC_W,
    parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             adc_valid,
    input  logic [ADC_W-1:0] adc_dout,
    output logic [ADC_W-1:0] mean,
    output logic             mean_vld
);

    localparam int ACC_W = ADC_W + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt;
    logic             last;

    assign sum  = acc + ACC_W'(adc_dout);
    assign last = (cnt == LAST_CNT);

    // Accumulate accepted samples; on the last one register the mean and restart
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            cnt      <= '0;
            mean     <= '0;
            mean_vld <= 1'b0;
        end else begin
            mean_vld <= 1'b0;
            if (!en) begin
                acc <= '0;
                cnt <= '0;
            end else if (adc_valid) begin
                if (last) begin
                    acc      <= '0;
                    cnt      <= '0;
                    mean     <= sum[ACC_W-1:AVG_LOG2];
                    mean_vld <= 1'b1;
                end else begin
                    acc <= sum;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/temp_led_meter.sv
// Thermometer-bar temperature meter. Averages ADC windows, maps the mean
// to a level with cooling hysteresis and drives an LED bar from the top.
// Optional sticky over-temperature alarm enabled by defining TEMP_ALARM_EN.
module temp_led_meter import temp_led_pkg::*; #(
    parameter int ADC_W    = DEF_ADC_W,
    parameter int LED_W    = DEF_LED_W,
    parameter int NUM_TH   = DEF_NUM_TH,
    parameter int AVG_LOG2 = DEF_AVG_LOG2,
    parameter int HYST     = DEF_HYST,
    parameter int ALARM_N  = DEF_ALARM_N
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic                            adc_valid,
    input  logic [ADC_W-1:0]                adc_dout,
    input  logic                            alarm_clr,
    output logic [LED_W-1:0]                led,
    output logic [level_width(NUM_TH)-1:0]  level,
    output logic                            upd,
    output logic                            alarm
);

    localparam int LVL_W = level_width(NUM_TH);
    localparam int CMP_W = ADC_W + 1;

    logic [ADC_W-1:0] mean;
    logic             mean_vld;
    logic [LVL_W-1:0] up;
    logic [LVL_W-1:0] dn;
    logic [LVL_W-1:0] level_nxt;

    temp_avg #(
        .ADC_W    (ADC_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .adc_valid (adc_valid),
        .adc_dout  (adc_dout),
        .mean      (mean),
        .mean_vld  (mean_vld)
    );

    // Count thresholds at or above the mean, plain and with the cooling margin
    always_comb begin
        up = '0;
        dn = '0;
        for (int i = 0; i < NUM_TH; i++) begin
            if ({1'b0, mean} <= CMP_W'(TEMP_TH[i]))
                up = up + 1'b1;
            if ({1'b0, mean} <= CMP_W'(TEMP_TH[i] + HYST))
                dn = dn + 1'b1;
        end
    end

    // Heating jumps straight up; cooling only drops once past the margin
    always_comb begin
        level_nxt = level;
        if (up > level)
            level_nxt = up;
        else if (dn < level)
            level_nxt = dn;
    end

    // Level register and the update strobe, one cycle after the mean lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
            upd   <= 1'b0;
        end else begin
            upd <= mean_vld;
            if (mean_vld)
                level <= level_nxt;
        end
    end

    // Light the bar from the top: bit i is lit when i >= NUM_TH - level
    always_comb begin
        led = '0;
        for (int i = 0; i < LED_W; i++)
            led[i] = (i >= (NUM_TH - int'(level)));
    end

`ifdef TEMP_ALARM_EN
    localparam int ACNT_W = (ALARM_N > 0) ? $clog2(ALARM_N + 1) : 1;

    logic [ACNT_W-1:0] alarm_cnt;
    logic [ACNT_W-1:0] alarm_cnt_nxt;
    logic              alarm_set;

    // Consecutive max-level updates, saturating; any cooler update restarts it
    always_comb begin
        alarm_cnt_nxt = alarm_cnt;
        if (level_nxt == LVL_W'(NUM_TH)) begin
            if (alarm_cnt != ACNT_W'(ALARM_N))
                alarm_cnt_nxt = alarm_cnt + 1'b1;
        end else begin
            alarm_cnt_nxt = '0;
        end
    end

    assign alarm_set = mean_vld && (alarm_cnt_nxt == ACNT_W'(ALARM_N));

    // Sticky alarm; a set landing with a clear takes priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_cnt <= '0;
            alarm     <= 1'b0;
        end else begin
            if (mean_vld)
                alarm_cnt <= alarm_cnt_nxt;
            alarm <= alarm_set | (alarm & ~alarm_clr);
        end
    end
`else
    logic unused_alarm_clr;

    assign unused_alarm_clr = alarm_clr;
    assign alarm            = 1'b0;
`endif

endmodule

// File: tb/tb_temp_led_meter.sv
// Self-checking bench for temp_led_meter at default parameters.
// Directed scenarios plus randomized windows against a behavioural model.
// Alarm checks follow TEMP_ALARM_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_temp_led_meter;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        adc_valid;
    logic [11:0] adc_dout;
    logic        alarm_clr;
    logic [7:0]  led;
    logic [2:0]  level;
    logic        upd;
    logic        alarm;

    int n_cmp;
    int n_fail;
    int upd_seen;

    // Thresholds in ADC counts, hottest last
    int th [6] = '{3666, 3643, 3625, 3595, 3576, 3550};

    temp_led_meter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .adc_valid (adc_valid),
        .adc_dout  (adc_dout),
        .alarm_clr (alarm_clr),
        .led       (led),
        .level     (level),
        .upd       (upd),
        .alarm     (alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every update pulse seen outside reset
    always @(negedge clk) begin
        if (rst_n === 1'b1 && upd === 1'b1)
            upd_seen++;
    end

    // Next level from a window mean and the current level
    function automatic int model_next(input int mean, input int cur);
        int up;
        int dn;
        up = 0;
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            if (mean <= th[i]) up++;
            if (mean <= th[i] + 4) dn++;
        end
        if (up > cur) return up;
        if (dn < cur) return dn;
        return cur;
    endfunction

    // Expected bar: the top (2 + lvl) of 8 bits set
    function automatic logic [7:0] model_led(input int lvl);
        int k;
        k = 2 + lvl;
        return 8'(((1 << k) - 1) << (8 - k));
    endfunction

    task automatic do_reset;
        rst_n     = 1'b0;
        en        = 1'b0;
        adc_valid = 1'b0;
        adc_dout  = '0;
        alarm_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Feed one window (optional random idle gaps), then wait for upd; lat = cycles, -1 on timeout
    task automatic run_window(input int s0, input int s1, input int s2, input int s3,
                              input int gap, output int lat);
        int s [4];
        int g;
        s = '{s0, s1, s2, s3};
        for (int k = 0; k < 4; k++) begin
            en        = 1'b1;
            adc_valid = 1'b1;
            adc_dout  = 12'(s[k]);
            @(posedge clk);
            #1;
            adc_valid = 1'b0;
            adc_dout  = 12'($urandom);
            if (k < 3) begin
                g = int'($urandom_range(0, gap));
                for (int j = 0; j < g; j++) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        lat = -1;
        for (int c = 1; c <= 8 && lat < 0; c++) begin
            @(negedge clk);
            if (upd === 1'b1) lat = c;
        end
    endtask

    task automatic test_window;
        int lat;
        $display("[TB] test_window");
        do_reset();
        n_cmp++;
        if (level !== 3'd0 || led !== 8'b11000000) begin
            n_fail++;
            $display("[TB] FAIL reset_state: level=%0d led=%b expected 0 / 11000000", level, led);
        end
        n_cmp++;
        if (upd !== 1'b0 || alarm !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_flags: upd=%b alarm=%b expected 0/0", upd, alarm);
        end
        run_window(3600, 3600, 3600, 3600, 0, lat);
        n_cmp++;
        if (lat !== 2) begin
            n_fail++;
            $display("[TB] FAIL window_latency: got %0d expected 2", lat);
        end
        n_cmp++;
        if (level !== 3'd3) begin
            n_fail++;
            $display("[TB] FAIL window_level: got %0d expected 3", level);
        end
        n_cmp++;
        if (led !== 8'b11111000) begin
            n_fail++;
            $display("[TB] FAIL window_led: got %b expected 11111000", led);
        end
        @(negedge clk);
        n_cmp++;
        if (upd !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL upd_one_cycle: got %b expected 0", upd);
        end
    endtask

    task automatic test_hysteresis;
        int lat;
        $display("[TB] test_hysteresis");
        run_window(3590, 3590, 3590, 3590, 0, lat);
        n_cmp++;
        if (lat !== 2 || led !== 8'b11111100) begin
            n_fail++;
            $display("[TB] FAIL hyst_heat: lat=%0d led=%b expected 2 / 11111100", lat, led);
        end
        run_window(3597, 3597, 3597, 3597, 0, lat);
        n_cmp++;
        if (lat !== 2 || led !== 8'b11111100) begin
            n_fail++;
            $display("[TB] FAIL hyst_hold: lat=%0d led=%b expected 2 / 11111100", lat, led);
        end
        run_window(3600, 3600, 3600, 3600, 0, lat);
        n_cmp++;
        if (lat !== 2 || led !== 8'b11111000 || level !== 3'd3) begin
            n_fail++;
            $display("[TB] FAIL hyst_cool: lat=%0d led=%b level=%0d expected 2 / 11111000 / 3", lat, led, level);
        end
    endtask

    task automatic test_jump;
        int lat;
        $display("[TB] test_jump");
        run_window(3550, 3550, 3550, 3550, 0, lat);
        n_cmp++;
        if (lat !== 2 || level !== 3'd6 || led !== 8'hFF) begin
            n_fail++;
            $display("[TB] FAIL jump_hot: lat=%0d level=%0d led=%b expected 2 / 6 / 11111111", lat, level, led);
        end
        run_window(3700, 3700, 3700, 3700, 0, lat);
        n_cmp++;
        if (lat !== 2 || level !== 3'd0 || led !== 8'b11000000) begin
            n_fail++;
            $display("[TB] FAIL jump_cold: lat=%0d level=%0d led=%b expected 2 / 0 / 11000000", lat, level, led);
        end
    endtask

    task automatic test_reset;
        int lat;
        $display("[TB] test_reset");
        run_window(3550, 3550, 3550, 3550, 0, lat);
        #2 rst_n = 1'b0;
        #2;
        n_cmp++;
        if (level !== 3'd0 || led !== 8'b11000000 || upd !== 1'b0 || alarm !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL async_reset: level=%0d led=%b upd=%b alarm=%b expected 0 / 11000000 / 0 / 0",
                     level, led, upd, alarm);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_enable;
        int lat;
        int base;
        $display("[TB] test_enable");
        do_reset();
        base = upd_seen;
        for (int k = 0; k < 2; k++) begin
            en = 1'b1; adc_valid = 1'b1; adc_dout = 12'd3500;
            @(posedge clk);
            #1;
        end
        en = 1'b0; adc_valid = 1'b1; adc_dout = 12'd0;
        @(posedge clk);
        #1;
        adc_valid = 1'b0;
        run_window(3600, 3600, 3600, 3600, 0, lat);
        n_cmp++;
        if (lat !== 2 || level !== 3'd3) begin
            n_fail++;
            $display("[TB] FAIL enable_clear: lat=%0d level=%0d expected 2 / 3", lat, level);
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (upd_seen - base !== 1) begin
            n_fail++;
            $display("[TB] FAIL enable_upd_count: got %0d expected 1", upd_seen - base);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        int base;
        $display("[TB] test_reset_mid");
        do_reset();
        for (int k = 0; k < 2; k++) begin
            en = 1'b1; adc_valid = 1'b1; adc_dout = 12'd3500;
            @(posedge clk);
            #1;
        end
        adc_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        base = upd_seen;
        run_window(3600, 3600, 3600, 3600, 0, lat);
        n_cmp++;
        if (lat !== 2 || level !== 3'd3) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_window: lat=%0d level=%0d expected 2 / 3", lat, level);
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (upd_seen - base !== 1) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_upd_count: got %0d expected 1", upd_seen - base);
        end
    endtask

    task automatic test_alarm;
        int lat;
        $display("[TB] test_alarm");
        do_reset();
`ifdef TEMP_ALARM_EN
        for (int w = 1; w <= 3; w++) begin
            run_window(3500, 3500, 3500, 3500, 0, lat);
            n_cmp++;
            if (lat !== 2 || alarm !== (w == 3)) begin
                n_fail++;
                $display("[TB] FAIL alarm_window%0d: lat=%0d alarm=%b expected 2 / %0d", w, lat, alarm, w == 3);
            end
        end
        alarm_clr = 1'b1;
        @(posedge clk);
        #1 alarm_clr = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (alarm !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL alarm_clear: got %b expected 0", alarm);
        end
        do_reset();
        for (int w = 1; w <= 2; w++) run_window(3500, 3500, 3500, 3500, 0, lat);
        alarm_clr = 1'b1;
        run_window(3500, 3500, 3500, 3500, 0, lat);
        n_cmp++;
        if (lat !== 2 || alarm !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL alarm_set_wins: lat=%0d alarm=%b expected 2 / 1", lat, alarm);
        end
        alarm_clr = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (alarm !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL alarm_sticky: got %b expected 1", alarm);
        end
`else
        for (int w = 1; w <= 3; w++) begin
            alarm_clr = 1'($urandom_range(0, 1));
            run_window(3500, 3500, 3500, 3500, 0, lat);
            n_cmp++;
            if (lat !== 2 || alarm !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL alarm_disabled%0d: lat=%0d alarm=%b expected 2 / 0", w, lat, alarm);
            end
        end
        alarm_clr = 1'b0;
`endif
    endtask

    task automatic test_random;
        int lat;
        int cur;
        int acnt;
        int aexp;
        int center;
        int s [4];
        int sum;
        $display("[TB] test_random");
        do_reset();
        cur  = 0;
        acnt = 0;
        aexp = 0;
        for (int w = 0; w < 40; w++) begin
            if ($urandom_range(0, 3) == 0) begin
                center = th[$urandom_range(0, 5)] + int'($urandom_range(0, 6)) - 1;
                for (int k = 0; k < 4; k++) s[k] = center;
            end else begin
                center = int'($urandom_range(3440, 3720));
                for (int k = 0; k < 4; k++) s[k] = center + int'($urandom_range(0, 16)) - 8;
            end
            sum = s[0] + s[1] + s[2] + s[3];
            cur = model_next(sum / 4, cur);
`ifdef TEMP_ALARM_EN
            if (cur == 6) acnt = (acnt < 3) ? acnt + 1 : 3;
            else acnt = 0;
            if (acnt == 3) aexp = 1;
`endif
            run_window(s[0], s[1], s[2], s[3], 3, lat);
            n_cmp++;
            if (lat !== 2 || level !== 3'(cur) || led !== model_led(cur)) begin
                n_fail++;
                $display("[TB] FAIL random_w%0d: lat=%0d level=%0d led=%b expected 2 / %0d / %b",
                         w, lat, level, led, cur, model_led(cur));
            end
            n_cmp++;
            if (alarm !== 1'(aexp)) begin
                n_fail++;
                $display("[TB] FAIL random_alarm_w%0d: got %b expected %0d", w, alarm, aexp);
            end
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        upd_seen  = 0;
        rst_n     = 1'b0;
        en        = 1'b0;
        adc_valid = 1'b0;
        adc_dout  = '0;
        alarm_clr = 1'b0;
        test_window();
        test_hysteresis();
        test_jump();
        test_reset();
        test_enable();
        test_reset_mid();
        test_alarm();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
